// File: rtl/cache_arbiter_n.sv
// cache_arbiter_n: N-channel L1-to-L2 request arbiter.
// Accepts one line-sized request at a time, forwards it to the single L2
// port and returns the L2 response to the granted channel only.
// Policy: fixed priority with aging (RR_MODE=0) or round-robin (RR_MODE=1).
module cache_arbiter_n #(
  parameter int N_CH     = 2,
  parameter int ADDR_W   = 32,
  parameter int LINE_W   = 128,
  parameter int RR_MODE  = 0,
  parameter int MAX_WAIT = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [N_CH-1:0]          req_valid_i,
  input  logic [N_CH-1:0]          req_rw_i,
  input  logic [N_CH*ADDR_W-1:0]   req_addr_i,
  input  logic [N_CH*LINE_W-1:0]   req_data_i,
  output logic [N_CH-1:0]          resp_ready_o,
  output logic [LINE_W-1:0]        resp_data_o,
  output logic                     mem_valid_o,
  output logic                     mem_rw_o,
  output logic [ADDR_W-1:0]        mem_addr_o,
  output logic [LINE_W-1:0]        mem_data_o,
  input  logic                     mem_ready_i,
  input  logic [LINE_W-1:0]        mem_data_i,
  output logic [N_CH-1:0]          grant_o,
  output logic                     busy_o
);

  localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              r_state;
  logic [N_CH-1:0]     r_grant;
  logic [CW-1:0]       r_gidx;
  logic [CW-1:0]       r_ptr;
  logic                r_mem_valid;
  logic                r_mem_rw;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [LINE_W-1:0]   r_mem_data;
  logic [N_CH-1:0]     r_resp_ready;
  logic [LINE_W-1:0]   r_resp_data;
  logic                r_busy;
  logic [3:0]          r_wait [N_CH];

  logic                w_any;
  logic                w_found;
  logic [CW-1:0]       w_win;
  logic [N_CH-1:0]     w_win_oh;
  logic [N_CH-1:0]     w_urgent;
  int unsigned         w_scan;

  assign w_any = |req_valid_i;

  // Urgent channels: valid requesters that have lost MAX_WAIT or more arbitrations
  always_comb begin
    w_urgent = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      w_urgent[k] = req_valid_i[k] && (r_wait[k] >= 4'(MAX_WAIT));
    end
  end

  // Winner selection for the current IDLE cycle
  always_comb begin
    w_win   = '0;
    w_found = 1'b0;
    w_scan  = 0;
    if (RR_MODE != 0) begin
      // Scan p, p+1, ... wrapping modulo N_CH; first valid channel wins
      for (int unsigned i = 0; i < N_CH; i++) begin
        w_scan = (32'(r_ptr) + i) % 32'(N_CH);
        if (!w_found && req_valid_i[w_scan]) begin
          w_win   = CW'(w_scan);
          w_found = 1'b1;
        end
      end
    end else if (|w_urgent) begin
      for (int unsigned k = 0; k < N_CH; k++) begin
        if (!w_found && w_urgent[k]) begin
          w_win   = CW'(k);
          w_found = 1'b1;
        end
      end
    end else begin
      for (int unsigned k = 0; k < N_CH; k++) begin
        if (!w_found && req_valid_i[k]) begin
          w_win   = CW'(k);
          w_found = 1'b1;
        end
      end
    end
  end

  // One-hot form of the winner index
  always_comb begin
    w_win_oh = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      w_win_oh[k] = (CW'(k) == w_win);
    end
  end

  // Arbitration FSM with registered outputs, wait counters and RR pointer
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= IDLE;
      r_grant      <= '0;
      r_gidx       <= '0;
      r_ptr        <= '0;
      r_mem_valid  <= 1'b0;
      r_mem_rw     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_data   <= '0;
      r_resp_ready <= '0;
      r_resp_data  <= '0;
      r_busy       <= 1'b0;
      for (int unsigned k = 0; k < N_CH; k++) begin
        r_wait[k] <= '0;
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_state     <= BUSY;
            r_gidx      <= w_win;
            r_grant     <= w_win_oh;
            r_mem_valid <= 1'b1;
            r_mem_rw    <= req_rw_i[w_win];
            r_mem_addr  <= req_addr_i[w_win*ADDR_W +: ADDR_W];
            r_mem_data  <= req_data_i[w_win*LINE_W +: LINE_W];
            r_busy      <= 1'b1;
            if (RR_MODE == 0) begin
              for (int unsigned k = 0; k < N_CH; k++) begin
                if (w_win_oh[k]) begin
                  r_wait[k] <= '0;
                end else if (req_valid_i[k] && (r_wait[k] != 4'hF)) begin
                  r_wait[k] <= r_wait[k] + 4'd1;
                end
              end
            end
          end
        end
        BUSY: begin
          if (mem_ready_i) begin
            r_resp_data  <= mem_data_i;
            r_mem_valid  <= 1'b0;
            r_resp_ready <= r_grant;
            r_state      <= RESP;
          end
        end
        RESP: begin
          r_resp_ready <= '0;
          r_grant      <= '0;
          r_busy       <= 1'b0;
          r_state      <= IDLE;
          if (RR_MODE != 0) begin
            r_ptr <= (r_gidx == CW'(N_CH - 1)) ? '0 : r_gidx + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign resp_ready_o = r_resp_ready;
  assign resp_data_o  = r_resp_data;
  assign mem_valid_o  = r_mem_valid;
  assign mem_rw_o     = r_mem_rw;
  assign mem_addr_o   = r_mem_addr;
  assign mem_data_o   = r_mem_data;
  assign grant_o      = r_grant;
  assign busy_o       = r_busy;

endmodule
